// File: rtl/hilo_unit.sv
// HI/LO register unit: tracks one outstanding multiply/divide, sinks its result, applies MTHI/MTLO.
// Optional MADD/MSUB accumulation is built only when HILO_ACC_EN is defined.
module hilo_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_issue_valid,
  input  logic        i_issue_is_div,
  input  logic [1:0]  i_issue_acc,
  input  logic        i_mult_res_valid,
  input  logic [63:0] i_mult_result,
  output logic        o_mult_res_ready,
  input  logic        i_div_res_valid,
  input  logic [63:0] i_div_result,
  output logic        o_div_res_ready,
  input  logic        i_flush,
  input  logic        i_mt_we_hi,
  input  logic        i_mt_we_lo,
  input  logic [31:0] i_mt_data,
  input  logic        i_mf_req,
  input  logic        i_mf_sel_hi,
  output logic [31:0] o_mf_data,
  output logic        o_stall_hilo
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitMul,
    StWaitDiv,
    StDrainMul,
    StDrainDiv
  } state_e;

  state_e      r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_mult_ready;
  logic        r_div_ready;
  logic        r_busy;

  logic        w_mul_take;
  logic        w_div_take;
  logic [63:0] w_mul_val;
  logic [63:0] w_res;

  // Only the non-flushed WAIT states commit a result; DRAIN handshakes are discarded.
  assign w_mul_take = (r_state == StWaitMul) & i_mult_res_valid & ~i_flush;
  assign w_div_take = (r_state == StWaitDiv) & i_div_res_valid & ~i_flush;

`ifdef HILO_ACC_EN
  logic [1:0]  r_acc_op;
  logic [63:0] w_hilo;
  logic [63:0] w_acc_sum;
  logic [63:0] w_acc_diff;

  assign w_hilo     = {r_hi, r_lo};
  assign w_acc_sum  = w_hilo + i_mult_result;
  assign w_acc_diff = w_hilo - i_mult_result;

  always_comb begin
    case (r_acc_op)
      2'b01:   w_mul_val = w_acc_sum;
      2'b10:   w_mul_val = w_acc_diff;
      default: w_mul_val = i_mult_result;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc_op <= 2'b00;
    end else if (r_state == StIdle && i_issue_valid && !i_flush) begin
      r_acc_op <= i_issue_acc;
    end
  end
`else
  logic w_unused_acc;
  assign w_unused_acc = ^i_issue_acc;
  assign w_mul_val    = i_mult_result;
`endif

  always_comb begin
    w_res = {r_hi, r_lo};
    if (w_mul_take) begin
      w_res = w_mul_val;
    end else if (w_div_take) begin
      w_res = i_div_result;
    end
  end

  // MT is the younger instruction, so it overrides the result for the half it writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= 32'h0;
      r_lo <= 32'h0;
    end else begin
      r_hi <= i_mt_we_hi ? i_mt_data : w_res[63:32];
      r_lo <= i_mt_we_lo ? i_mt_data : w_res[31:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_mult_ready <= 1'b0;
      r_div_ready  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_issue_valid && !i_flush) begin
            r_busy <= 1'b1;
            if (i_issue_is_div) begin
              r_state     <= StWaitDiv;
              r_div_ready <= 1'b1;
            end else begin
              r_state      <= StWaitMul;
              r_mult_ready <= 1'b1;
            end
          end
        end
        StWaitMul: begin
          if (i_mult_res_valid) begin
            r_state      <= StIdle;
            r_mult_ready <= 1'b0;
            r_busy       <= 1'b0;
          end else if (i_flush) begin
            r_state <= StDrainMul;
          end
        end
        StWaitDiv: begin
          if (i_div_res_valid) begin
            r_state     <= StIdle;
            r_div_ready <= 1'b0;
            r_busy      <= 1'b0;
          end else if (i_flush) begin
            r_state <= StDrainDiv;
          end
        end
        StDrainMul: begin
          if (i_mult_res_valid) begin
            r_state      <= StIdle;
            r_mult_ready <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        StDrainDiv: begin
          if (i_div_res_valid) begin
            r_state     <= StIdle;
            r_div_ready <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state      <= StIdle;
          r_mult_ready <= 1'b0;
          r_div_ready  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_mult_res_ready = r_mult_ready;
  assign o_div_res_ready  = r_div_ready;
  assign o_mf_data        = i_mf_sel_hi ? r_hi : r_lo;
  assign o_stall_hilo     = i_mf_req & r_busy;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: expected {hi,lo} values queued at stimulus time,
// popped and compared after each result handshake or MT write.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_is_div = 1'b0;
  logic [1:0]  issue_acc = 2'b00;
  logic        mult_res_valid = 1'b0;
  logic [63:0] mult_result = 64'h0;
  logic        mult_res_ready;
  logic        div_res_valid = 1'b0;
  logic [63:0] div_result = 64'h0;
  logic        div_res_ready;
  logic        flush = 1'b0;
  logic        mt_we_hi = 1'b0;
  logic        mt_we_lo = 1'b0;
  logic [31:0] mt_data = 32'h0;
  logic        mf_req = 1'b0;
  logic        mf_sel_hi = 1'b0;
  logic [31:0] mf_data;
  logic        stall_hilo;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] m_hilo = 64'h0;

  always #5 clk = ~clk;

  hilo_unit u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_issue_valid   (issue_valid),
    .i_issue_is_div  (issue_is_div),
    .i_issue_acc     (issue_acc),
    .i_mult_res_valid(mult_res_valid),
    .i_mult_result   (mult_result),
    .o_mult_res_ready(mult_res_ready),
    .i_div_res_valid (div_res_valid),
    .i_div_result    (div_result),
    .o_div_res_ready (div_res_ready),
    .i_flush         (flush),
    .i_mt_we_hi      (mt_we_hi),
    .i_mt_we_lo      (mt_we_lo),
    .i_mt_data       (mt_data),
    .i_mf_req        (mf_req),
    .i_mf_sel_hi     (mf_sel_hi),
    .o_mf_data       (mf_data),
    .o_stall_hilo    (stall_hilo)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] v);
    sb_q.push_back(v);
    m_hilo = v;
  endtask

  // Pops the oldest expected {hi,lo} and reads both halves through the MF port.
  task automatic check_sb(input string name);
    logic [63:0] e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got hi=%h lo=%h", name, u_dut.o_mf_data, 32'h0);
    end else begin
      e = sb_q.pop_front();
      mf_sel_hi = 1'b1;
      #1;
      if (mf_data !== e[63:32]) begin
        n_err++;
        $display("FAIL %s hi: got %h expected %h", name, mf_data, e[63:32]);
      end
      n_vec++;
      mf_sel_hi = 1'b0;
      #1;
      if (mf_data !== e[31:0]) begin
        n_err++;
        $display("FAIL %s lo: got %h expected %h", name, mf_data, e[31:0]);
      end
    end
  endtask

  task automatic do_issue(input logic is_div, input logic [1:0] acc);
    issue_valid  = 1'b1;
    issue_is_div = is_div;
    issue_acc    = acc;
    cyc();
    issue_valid  = 1'b0;
    issue_acc    = 2'b00;
  endtask

  // Waits (bounded) for the right ready, then presents the result plus junk on the other source.
  task automatic drive_res(input logic is_div, input logic [63:0] r, input logic junk_other);
    int k = 0;
    while (((is_div ? div_res_ready : mult_res_ready) !== 1'b1) && k < 10) begin
      cyc();
      k++;
    end
    n_vec++;
    if ((is_div ? div_res_ready : mult_res_ready) !== 1'b1) begin
      n_err++;
      $display("FAIL ready_wait: got 0 expected 1 (is_div=%0d)", is_div);
    end
    if (is_div) begin
      div_res_valid  = 1'b1;
      div_result     = r;
      mult_res_valid = junk_other;
      mult_result    = 64'hDEAD_BEEF_DEAD_BEEF;
    end else begin
      mult_res_valid = 1'b1;
      mult_result    = r;
      div_res_valid  = junk_other;
      div_result     = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    #1;
    n_vec++;
    if ((is_div ? mult_res_ready : div_res_ready) !== 1'b0) begin
      n_err++;
      $display("FAIL other_ready: got 1 expected 0 (is_div=%0d)", is_div);
    end
    cyc();
    mult_res_valid = 1'b0;
    div_res_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    mf_req = 1'b1;
    mf_sel_hi = 1'b1;
    #1;
    n_vec++;
    if (mf_data !== 32'h0 || stall_hilo !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mfhi: got data=%h stall=%b expected 0/0", mf_data, stall_hilo);
    end
    n_vec++;
    if (mult_res_ready !== 1'b0 || div_res_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got %b%b expected 00", mult_res_ready, div_res_ready);
    end
    mf_req = 1'b0;
    push_exp(64'h0);
    check_sb("reset_hilo");
  endtask

  task automatic test_mult();
    do_issue(1'b0, 2'b00);
    mf_req = 1'b1;
    mf_sel_hi = 1'b1;
    #1;
    n_vec++;
    if (stall_hilo !== 1'b1 || mult_res_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mult_wait: got stall=%b ready=%b expected 1/1", stall_hilo, mult_res_ready);
    end
    cyc();
    n_vec++;
    if (stall_hilo !== 1'b1) begin
      n_err++;
      $display("FAIL mult_stall_hold: got %b expected 1", stall_hilo);
    end
    push_exp(64'h0000_0001_FFFF_FFFE);
    drive_res(1'b0, 64'h0000_0001_FFFF_FFFE, 1'b0);
    n_vec++;
    if (stall_hilo !== 1'b0 || mf_data !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL mult_release: got stall=%b data=%h expected 0/00000001", stall_hilo,
               mf_data);
    end
    mf_req = 1'b0;
    check_sb("mult_result");
  endtask

  task automatic test_acc();
    mt_we_hi = 1'b1;
    mt_data  = 32'h0;
    cyc();
    mt_we_hi = 1'b0;
    mt_we_lo = 1'b1;
    mt_data  = 32'hFFFF_FFFF;
    cyc();
    mt_we_lo = 1'b0;
    push_exp(64'h0000_0000_FFFF_FFFF);
    check_sb("acc_preload");
    do_issue(1'b0, 2'b01);
`ifdef HILO_ACC_EN
    push_exp(64'h0000_0001_0000_0000);
`else
    push_exp(64'h0000_0000_0000_0001);
`endif
    drive_res(1'b0, 64'h1, 1'b0);
    check_sb("madd");
    do_issue(1'b0, 2'b10);
`ifdef HILO_ACC_EN
    push_exp(64'h0000_0000_FFFF_FFFE);
`else
    push_exp(64'h0000_0000_0000_0002);
`endif
    drive_res(1'b0, 64'h2, 1'b0);
    check_sb("msub");
    do_issue(1'b0, 2'b11);
    push_exp(64'h0000_0003_0000_0004);
    drive_res(1'b0, 64'h0000_0003_0000_0004, 1'b0);
    check_sb("acc_reserved");
  endtask

  task automatic test_flush_div();
    do_issue(1'b1, 2'b00);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    mf_req = 1'b1;
    #1;
    n_vec++;
    if (div_res_ready !== 1'b1 || stall_hilo !== 1'b1) begin
      n_err++;
      $display("FAIL drain_div: got ready=%b stall=%b expected 1/1", div_res_ready, stall_hilo);
    end
    push_exp(m_hilo);
    drive_res(1'b1, 64'h0000_0005_0000_0007, 1'b0);
    n_vec++;
    if (div_res_ready !== 1'b0 || stall_hilo !== 1'b0) begin
      n_err++;
      $display("FAIL drain_exit: got ready=%b stall=%b expected 0/0", div_res_ready, stall_hilo);
    end
    mf_req = 1'b0;
    check_sb("flush_discard");
    issue_valid = 1'b1;
    flush = 1'b1;
    cyc();
    issue_valid = 1'b0;
    flush = 1'b0;
    n_vec++;
    if (mult_res_ready !== 1'b0 || div_res_ready !== 1'b0) begin
      n_err++;
      $display("FAIL issue_flush_drop: got %b%b expected 00", mult_res_ready, div_res_ready);
    end
  endtask

  task automatic test_mt_collision();
    do_issue(1'b0, 2'b00);
    mt_we_lo = 1'b1;
    mt_data  = 32'h55;
    push_exp(64'h0000_000A_0000_0055);
    drive_res(1'b0, 64'h0000_000A_0000_000B, 1'b0);
    mt_we_lo = 1'b0;
    check_sb("mt_collision");
  endtask

  task automatic test_rst_mid();
    do_issue(1'b0, 2'b00);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mult_res_valid = 1'b1;
    mult_result = 64'h1234_5678_9ABC_DEF0;
    mf_req = 1'b1;
    #1;
    n_vec++;
    if (mult_res_ready !== 1'b0 || stall_hilo !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: got ready=%b stall=%b expected 0/0", mult_res_ready, stall_hilo);
    end
    cyc();
    mult_res_valid = 1'b0;
    mf_req = 1'b0;
    push_exp(64'h0);
    check_sb("rst_mid_hilo");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [63:0] r;
      logic        d;
      r = {$urandom, $urandom};
      d = (i % 2) == 1;
      do_issue(d, 2'b00);
      push_exp(r);
      drive_res(d, r, 1'b1);
      check_sb("back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_acc();
    test_flush_div();
    test_mt_collision();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
